spi_tx_fifo_master: RTL and testbench
=====================================

SPI_TX_FIFO_MASTER -- requirements
Module: spi_tx_fifo_master

Interface
REQ-001 Parameter: DATA_W, 8, frame width in bits; legal 4..32.
REQ-002 Parameter: FIFO_DEPTH, 16, entries; power of two, 2..256.
REQ-003 Parameter: PRESC_W, 8, prescaler width.
REQ-004 Port: clk  in  1  single clock; all logic on rising edge.
REQ-005 Port: reset  in  1  asynchronous, active-low reset.
REQ-006 Port: enable  in  1  1 = start frames from the FIFO; 0 = finish the current frame, then idle.
REQ-007 Port: mode  in  2  [1] = CPOL, [0] = CPHA; sampled at frame start.
REQ-008 Port: prescaler  in  PRESC_W  SCL half-period = prescaler+1 clk; sampled at frame start.
REQ-009 Port: wr_en  in  1  push request.
REQ-010 Port: wr_data  in  DATA_W  frame payload.
REQ-011 Port: wr_dc  in  1  D/C bit stored with the payload; 0 = command, 1 = data.
REQ-012 Port: full, empty  out  1 each  FIFO status.
REQ-013 Port: level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-014 Port: overflow  out  1  one-clk pulse when a push is dropped.
REQ-015 Port: cs_n, dc, scl, sda  out  1 each  SPI pins, all registered.
REQ-016 Port: busy  out  1  high in any state other than IDLE.
REQ-017 Port: done  out  1  one-clk pulse when a frame's HOLD ends.

Function
REQ-018 The FIFO SHALL store {wr_dc, wr_data}; a push SHALL be accepted when wr_en=1 and full=0; when full=1 the push SHALL be dropped and overflow SHALL pulse, even if a pop happens in the same cycle.
REQ-019 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave level unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, GAP; every non-IDLE state lasts in whole half-periods counted by a PRESC_W-bit down-counter.
REQ-021 IDLE -> SETUP when enable=1 and empty=0: pop one entry, latch mode, prescaler and dc, assert cs_n=0; the pin change appears 1 clk after the pop.
REQ-022 SETUP lasts one half-period; with CPHA=0, sda SHALL carry the MSB throughout SETUP.
REQ-023 SHIFT SHALL produce 2*DATA_W SCL edges, one per half-period, starting from idle level CPOL; data SHALL be MSB first.
REQ-024 With CPHA=0, sda SHALL change on trailing edges; with CPHA=1, sda SHALL change on leading edges, the MSB appearing at the first leading edge.
REQ-025 HOLD lasts one half-period with scl=CPOL and cs_n=0; at its end done SHALL pulse and cs_n SHALL go to 1.
REQ-026 GAP lasts one half-period with cs_n=1; then go to SETUP if enable=1 and empty=0 (pop as in REQ-021), otherwise to IDLE.
REQ-027 Deasserting enable mid-frame SHALL NOT abort the frame; changes to mode or prescaler mid-frame SHALL be ignored.
REQ-028 In IDLE: scl = mode[1] (live), cs_n=1, sda=0, and dc SHALL hold the last frame's value.
REQ-029 prescaler=0 SHALL give SCL = clk/2; prescaler=2^PRESC_W-1 SHALL work without counter overflow.

Reset
REQ-030 While reset=0: cs_n=1, scl=0, sda=0, dc=0, busy=0, done=0, overflow=0, FIFO empty (level=0), state IDLE.
REQ-031 Reset asserted mid-frame SHALL abort immediately with no partial-frame completion or done pulse; FIFO contents SHALL be discarded.

Structure
REQ-032 A shared package spi_pkg SHALL hold the FSM state enum, CPOL/CPHA bit-index constants, and the mode encodings MODE0..MODE3.
REQ-033 The FIFO SHALL be a separate sub-module, spi_sync_fifo (parametrised width and depth; full, empty, level outputs), reusable by a later RX path.

Verification
REQ-034 DATA_W=8, mode=00, prescaler=1, push 0xA5 dc=1 -> cs_n low, dc=1, 16 SCL edges of period 4 clk, MOSI sampled on rising edges = 1010_0101, done pulses once.
REQ-035 mode=11, push 0x3C then 0xC3, enable held -> two frames; scl idles high; GAP of cs_n=1 for exactly prescaler+1 clk between frames; empty=1 after the second pop.
REQ-036 FIFO_DEPTH=4, five pushes with enable=0 -> full=1, level=4, overflow pulses once on the fifth push, the fifth word is never transmitted.
REQ-037 Drop enable during bit 3 of a frame -> frame completes with done, cs_n returns high, no further pop although empty=0.
REQ-038 Assert reset at SHIFT edge 5 -> next clk: cs_n=1, scl=0, busy=0, level=0; no done pulse.
REQ-039 prescaler=0, DATA_W=16, mode=01 -> SCL period 2 clk, 32 edges, sda changes on rising edges, word 0x8001 received intact.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit path: FSM states, mode bit
// positions and the four standard SPI mode encodings.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock show-ahead FIFO. The head entry is always visible on
// pop_data, so a consumer can take it in the same cycle it pops.
// Pushes into a full FIFO are dropped and flagged on overflow one cycle
// later, regardless of any simultaneous pop.
module spi_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == (AW + 1)'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push && full;
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_fifo_master.sv
// SPI transmit master fed from a FIFO of {dc, payload} words. Each frame
// is framed by cs_n, shifted MSB first in any of the four SPI modes, and
// paced by a half-period down-counter reloaded from the prescaler.
module spi_tx_fifo_master
  import spi_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PRESC_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic [PRESC_W-1:0]            prescaler,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          wr_dc,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          cs_n,
  output logic                          dc,
  output logic                          scl,
  output logic                          sda,
  output logic                          busy,
  output logic                          done
);

  localparam int EW = $clog2(2 * DATA_W);

  spi_state_t         state_q, state_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [EW-1:0]      edges_q, edges_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               cpol_q, cpol_d;
  logic               cpha_q, cpha_d;
  logic               cs_n_d, dc_d, scl_d, sda_d, done_d;
  logic               pop, start, toggle, half_end;
  logic [DATA_W-1:0]  fifo_data;
  logic               fifo_dc;

  spi_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_en),
    .push_data ({wr_dc, wr_data}),
    .pop       (pop),
    .pop_data  ({fifo_dc, fifo_data}),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow)
  );

  assign busy = (state_q != ST_IDLE);

  // Next-state and next-pin logic; every pin is a register fed from here.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    presc_d  = presc_q;
    edges_d  = edges_q;
    shreg_d  = shreg_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    cs_n_d   = cs_n;
    dc_d     = dc;
    scl_d    = scl;
    sda_d    = sda;
    done_d   = 1'b0;
    pop      = 1'b0;
    start    = 1'b0;
    toggle   = 1'b0;
    half_end = (cnt_q == '0);

    if (state_q != ST_IDLE && !half_end) begin
      cnt_d = cnt_q - PRESC_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        scl_d  = mode[CPOL_BIT];
        cs_n_d = 1'b1;
        sda_d  = 1'b0;
        start  = enable && !empty;
      end
      ST_SETUP: begin
        if (half_end) begin
          state_d = ST_SHIFT;
          cnt_d   = presc_q;
          edges_d = EW'(2 * DATA_W - 1);
          toggle  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (half_end) begin
          cnt_d = presc_q;
          if (edges_q == '0) begin
            state_d = ST_HOLD;
          end else begin
            edges_d = edges_q - EW'(1);
            toggle  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (half_end) begin
          state_d = ST_GAP;
          cnt_d   = presc_q;
          cs_n_d  = 1'b1;
          sda_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (half_end) begin
          if (enable && !empty) begin
            start = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (toggle) begin
      scl_d = ~scl;
      if ((scl == cpol_q) == cpha_q) begin
        sda_d   = shreg_q[DATA_W-1];
        shreg_d = shreg_q << 1;
      end
    end

    if (start) begin
      pop     = 1'b1;
      state_d = ST_SETUP;
      cnt_d   = prescaler;
      presc_d = prescaler;
      cpol_d  = mode[CPOL_BIT];
      cpha_d  = mode[CPHA_BIT];
      dc_d    = fifo_dc;
      cs_n_d  = 1'b0;
      scl_d   = mode[CPOL_BIT];
      if (mode[CPHA_BIT]) begin
        sda_d   = 1'b0;
        shreg_d = fifo_data;
      end else begin
        sda_d   = fifo_data[DATA_W-1];
        shreg_d = fifo_data << 1;
      end
    end
  end

  // State, timing and pin registers; reset drops any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      presc_q          <= '0;
      edges_q          <= '0;
      shreg_q          <= '0;
      {cpol_q, cpha_q} <= MODE0;
      cs_n             <= 1'b1;
      dc               <= 1'b0;
      scl              <= 1'b0;
      sda              <= 1'b0;
      done             <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      edges_q <= edges_d;
      shreg_q <= shreg_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      cs_n    <= cs_n_d;
      dc      <= dc_d;
      scl     <= scl_d;
      sda     <= sda_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_tx_fifo_master.sv
// Bench for spi_tx_fifo_master: an SPI slave monitor decodes the pins into
// frames, which are compared with the words the bench pushed.
module tb_spi_tx_fifo_master;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int PRESC_W    = 8;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic                        enable = 1'b0;
  logic [1:0]                  mode = 2'b00;
  logic [PRESC_W-1:0]          prescaler = '0;
  logic                        wr_en = 1'b0;
  logic [DATA_W-1:0]           wr_data = '0;
  logic                        wr_dc = 1'b0;
  logic                        full, empty, overflow;
  logic [$clog2(FIFO_DEPTH):0] level;
  logic                        cs_n, dc, scl, sda, busy, done;

  typedef struct {
    logic [DATA_W-1:0] word;
    logic              dcv;
    int                edges;
    int                bad;
    int                setup_len;
    int                hold_len;
    int                gap;
    int                presc;
    logic              done_end;
  } frame_t;

  int                checks = 0;
  int                errors = 0;
  logic [DATA_W:0]   exp_q[$];
  frame_t            rx_q[$];
  logic [1:0]        frame_mode = 2'b00;
  int                frame_presc = 0;

  bit                in_frame = 1'b0;
  logic [DATA_W-1:0] mon_word;
  logic              mon_last_scl, mon_dc;
  logic [1:0]        mon_mode;
  int                mon_edges = 0, mon_bad, mon_setup, mon_since, mon_presc, mon_gap;
  int                mon_high = 0, done_total = 0, ov_total = 0;

  spi_tx_fifo_master #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .PRESC_W    (PRESC_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .mode      (mode),
    .prescaler (prescaler),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_dc     (wr_dc),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .cs_n      (cs_n),
    .dc        (dc),
    .scl       (scl),
    .sda       (sda),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // SPI slave monitor sampling pins on the falling clk edge.
  always @(negedge clk) begin
    frame_t f;
    if (done === 1'b1) done_total++;
    if (overflow === 1'b1) ov_total++;
    if (reset === 1'b0) begin
      in_frame = 1'b0;
      mon_high = 0;
    end else if (!in_frame) begin
      if (cs_n === 1'b0) begin
        in_frame     = 1'b1;
        mon_gap      = mon_high + 1;
        mon_word     = '0;
        mon_edges    = 0;
        mon_bad      = 0;
        mon_setup    = -1;
        mon_since    = 0;
        mon_last_scl = scl;
        mon_mode     = frame_mode;
        mon_presc    = frame_presc;
        mon_dc       = dc;
      end else begin
        mon_high++;
      end
    end else begin
      mon_since++;
      if (scl !== mon_last_scl) begin
        mon_edges++;
        if ((mon_last_scl == mon_mode[1]) != mon_mode[0]) begin
          mon_word = {mon_word[DATA_W-2:0], sda};
        end
        if (mon_edges == 1) mon_setup = mon_since;
        else if (mon_since != mon_presc + 1) mon_bad++;
        mon_since    = 0;
        mon_last_scl = scl;
      end
      if (cs_n === 1'b1) begin
        f.word      = mon_word;
        f.dcv       = mon_dc;
        f.edges     = mon_edges;
        f.bad       = mon_bad;
        f.setup_len = mon_setup;
        f.hold_len  = mon_since;
        f.gap       = mon_gap;
        f.presc     = mon_presc;
        f.done_end  = done;
        rx_q.push_back(f);
        in_frame = 1'b0;
        mon_high = 0;
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one word; only used while the master is idle with enable low.
  task automatic apply_stimulus(input logic [DATA_W-1:0] d, input logic dcv);
    wr_en   = 1'b1;
    wr_data = d;
    wr_dc   = dcv;
    tick();
    wr_en = 1'b0;
    if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({dcv, d});
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_output("frame_arrival", rx_q.size() >= n, 1);
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    check_output("return_idle", busy, 0);
  endtask

  task automatic wait_cs_low(input string tag);
    int k = 0;
    while (cs_n !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    check_output(tag, cs_n, 0);
  endtask

  task automatic check_frame(input string tag, output int gap);
    frame_t          f;
    logic [DATA_W:0] e;
    gap = -1;
    check_output({tag, "_have"}, (rx_q.size() != 0 && exp_q.size() != 0), 1);
    if (rx_q.size() != 0 && exp_q.size() != 0) begin
      f   = rx_q.pop_front();
      e   = exp_q.pop_front();
      gap = f.gap;
      check_output({tag, "_word"}, f.word, e[DATA_W-1:0]);
      check_output({tag, "_dc"}, f.dcv, e[DATA_W]);
      check_output({tag, "_edges"}, f.edges, 2 * DATA_W);
      check_output({tag, "_halfperiod"}, f.bad, 0);
      check_output({tag, "_setup"}, f.setup_len, f.presc + 1);
      check_output({tag, "_hold"}, f.hold_len, 2 * (f.presc + 1));
      check_output({tag, "_done"}, f.done_end, 1);
    end
  endtask

  task automatic idle_checks(input string tag, input logic exp_dc);
    check_output({tag, "_cs_n"}, cs_n, 1);
    check_output({tag, "_sda"}, sda, 0);
    check_output({tag, "_scl"}, scl, mode[1]);
    check_output({tag, "_dc"}, dc, exp_dc);
  endtask

  initial begin
    int                 g;
    int                 dtot;
    int                 otot;
    int                 k;
    int                 p;
    logic [DATA_W-1:0]  d;
    logic               dv;

    // Reset values
    prescaler = PRESC_W'(1);
    repeat (3) tick();
    check_output("rst_cs_n", cs_n, 1);
    check_output("rst_scl", scl, 0);
    check_output("rst_sda", sda, 0);
    check_output("rst_dc", dc, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_empty", empty, 1);
    check_output("rst_full", full, 0);
    check_output("rst_level", level, 0);
    reset = 1'b1;
    repeat (2) tick();

    // Mode 0, prescaler 1, single data frame 0xA5
    frame_mode = 2'b00; frame_presc = 1; mode = 2'b00; prescaler = PRESC_W'(1);
    apply_stimulus(8'hA5, 1'b1);
    check_output("a5_level", level, exp_q.size());
    enable = 1'b1;
    wait_frames(1, 2000);
    check_frame("a5", g);
    check_output("a5_done_count", done_total, 1);
    tick();
    idle_checks("a5_idle", 1'b1);
    enable = 1'b0;

    // Mode 3, two back-to-back frames with enable held
    frame_mode = 2'b11; frame_presc = 2; mode = 2'b11; prescaler = PRESC_W'(2);
    repeat (2) tick();
    apply_stimulus(8'h3C, 1'b0);
    apply_stimulus(8'hC3, 1'b1);
    check_output("m3_level", level, exp_q.size());
    enable = 1'b1;
    wait_frames(2, 3000);
    check_frame("m3_first", g);
    check_frame("m3_second", g);
    check_output("m3_gap", g, 3);
    check_output("m3_empty", empty, 1);
    check_output("m3_done_count", done_total, 3);
    tick();
    idle_checks("m3_idle", 1'b1);
    enable = 1'b0;

    // Overflow: five pushes into a four-entry FIFO with enable low
    frame_mode = 2'b01; frame_presc = 0; mode = 2'b01; prescaler = '0;
    repeat (2) tick();
    otot = ov_total;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(DATA_W'($urandom), 1'($urandom));
      check_output("ovf_level", level, exp_q.size());
    end
    check_output("ovf_full", full, 1);
    repeat (2) tick();
    check_output("ovf_pulses", ov_total - otot, 1);
    enable = 1'b1;
    wait_frames(4, 2000);
    for (int i = 0; i < 4; i++) check_frame("ovf_frame", g);
    repeat (40) tick();
    check_output("ovf_no_fifth", rx_q.size(), 0);
    check_output("ovf_empty", empty, 1);
    enable = 1'b0;

    // Enable dropped mid-frame while mode and prescaler also change
    p = $urandom_range(1, 3);
    frame_mode = 2'($urandom); frame_presc = p;
    mode = frame_mode; prescaler = PRESC_W'(p);
    repeat (2) tick();
    apply_stimulus(DATA_W'($urandom), 1'($urandom));
    apply_stimulus(DATA_W'($urandom), 1'($urandom));
    enable = 1'b1;
    wait_cs_low("drop_start");
    repeat ((p + 1) * 6) tick();
    enable = 1'b0;
    mode = ~frame_mode;
    prescaler = PRESC_W'(p + 4);
    wait_frames(1, 2000);
    check_frame("drop", g);
    repeat (60) tick();
    check_output("drop_no_pop", rx_q.size(), 0);
    check_output("drop_level", level, 1);
    check_output("drop_empty", empty, 0);
    check_output("drop_done_count", done_total, 8);

    // Reset during the shift phase
    frame_mode = 2'b00; frame_presc = 1; mode = 2'b00; prescaler = PRESC_W'(1);
    repeat (2) tick();
    apply_stimulus(DATA_W'($urandom), 1'($urandom));
    check_output("rst_mid_level_before", level, 2);
    enable = 1'b1;
    wait_cs_low("rst_mid_start");
    check_output("rst_mid_level_pop", level, 1);
    k = 0;
    while (mon_edges < 5 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_output("rst_mid_edge5", mon_edges >= 5, 1);
    dtot = done_total;
    reset = 1'b0;
    enable = 1'b0;
    exp_q.delete();
    tick();
    check_output("rst_mid_cs_n", cs_n, 1);
    check_output("rst_mid_scl", scl, 0);
    check_output("rst_mid_busy", busy, 0);
    check_output("rst_mid_level", level, 0);
    check_output("rst_mid_done", done, 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    check_output("rst_mid_no_done", done_total, dtot);
    check_output("rst_mid_no_frame", rx_q.size(), 0);

    // Directed corner prescalers followed by randomized frames
    for (int i = 0; i < 8; i++) begin
      enable = 1'b0;
      if (i == 0) begin
        frame_mode = 2'b01; frame_presc = 0; d = 8'h81; dv = 1'b0;
      end else if (i == 1) begin
        frame_mode = 2'b10; frame_presc = (1 << PRESC_W) - 1; d = 8'h5A; dv = 1'b1;
      end else begin
        frame_mode = 2'($urandom); frame_presc = $urandom_range(0, 3);
        d = DATA_W'($urandom); dv = 1'($urandom);
      end
      mode = frame_mode;
      prescaler = PRESC_W'(frame_presc);
      repeat (2) tick();
      apply_stimulus(d, dv);
      enable = 1'b1;
      wait_frames(1, 8000);
      check_frame("rand", g);
      tick();
      idle_checks("rand_idle", dv);
    end
    check_output("final_done_count", done_total, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
